// File: rtl/telemetry_tx_scheduler.sv
// Schedules periodic telemetry frames and one-shot urgent event frames onto a
// byte-wide UART transmit handshake, one byte at a time, with an XOR checksum.
module telemetry_tx_scheduler #(
    parameter int unsigned PERIOD_CYCLES = 5_000_000,
    parameter logic [7:0]  HEADER        = 8'hA5
) (
    input  logic       c50M,
    input  logic       reset,
    input  logic [7:0] speed,
    input  logic [7:0] heartRate,
    input  logic [9:0] resolvedAngle,
    input  logic [11:0] adcData,
    input  logic       event_req,
    input  logic [7:0] event_code,
    input  logic       is_transmitting,
    output logic       transmit,
    output logic [7:0] tx_byte,
    output logic       busy,
    output logic [7:0] frame_count,
    output logic       overrun,
    output logic       event_drop,
    output logic [2:0] state_dbg
);

    // Handshake: transmit is a single-cycle request carrying tx_byte; the UART
    // answers with is_transmitting, which is only trusted from the WAIT state on.
    localparam int CNT_W = $clog2(PERIOD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SNAP = 3'd1,
        S_SEND = 3'd2,
        S_HOLD = 3'd3,
        S_WAIT = 3'd4
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] period_cnt;
    logic             tick;
    logic             tel_pend, ev_pend;
    logic             tel_clr, ev_clr;
    logic [7:0]       ev_code;
    logic [7:0]       frame_buf [0:8];
    logic             frame_is_ev;
    logic [3:0]       idx;
    logic [3:0]       last_idx;
    logic             is_last;
    logic [7:0]       chk;
    logic [7:0]       cur_byte;
    logic [7:0]       tx_hold;

    always_comb begin
        tick     = (period_cnt == CNT_LAST);
        ev_clr   = (state == S_SNAP) && ev_pend;
        tel_clr  = (state == S_SNAP) && !ev_pend;
        last_idx = frame_is_ev ? 4'd4 : 4'd9;
        is_last  = (idx == last_idx);
        cur_byte = 8'h00;
        if (is_last) cur_byte = chk;
        else         cur_byte = frame_buf[idx];
    end

    always_comb begin
        state_nx = state;
        transmit = 1'b0;
        case (state)
            S_IDLE: if ((ev_pend || tel_pend) && !is_transmitting) state_nx = S_SNAP;
            S_SNAP: state_nx = S_SEND;
            S_SEND: begin
                transmit = 1'b1;
                state_nx = S_HOLD;
            end
            S_HOLD: state_nx = S_WAIT;
            S_WAIT: if (!is_transmitting) state_nx = is_last ? S_IDLE : S_SEND;
            default: state_nx = S_IDLE;
        endcase
        tx_byte   = (state == S_SEND) ? cur_byte : tx_hold;
        busy      = (state != S_IDLE);
        state_dbg = state;
    end

    always_ff @(posedge c50M) begin
        if (reset) begin
            state       <= S_IDLE;
            period_cnt  <= '0;
            tel_pend    <= 1'b0;
            ev_pend     <= 1'b0;
            ev_code     <= 8'h00;
            overrun     <= 1'b0;
            event_drop  <= 1'b0;
            frame_count <= 8'h00;
            frame_is_ev <= 1'b0;
            idx         <= 4'd0;
            chk         <= 8'h00;
            tx_hold     <= 8'h00;
            for (int i = 0; i < 9; i++) frame_buf[i] <= 8'h00;
        end else begin
            state      <= state_nx;
            period_cnt <= tick ? '0 : period_cnt + CNT_W'(1);

            // A new tick or event in the same cycle as its clear is kept, not lost.
            if (tick) begin
                tel_pend <= 1'b1;
                if (tel_pend && !tel_clr) overrun <= 1'b1;
            end else if (tel_clr) begin
                tel_pend <= 1'b0;
            end

            if (event_req) begin
                if (ev_pend && !ev_clr) begin
                    event_drop <= 1'b1;
                end else begin
                    ev_pend <= 1'b1;
                    ev_code <= event_code;
                end
            end else if (ev_clr) begin
                ev_pend <= 1'b0;
            end

            case (state)
                S_SNAP: begin
                    frame_is_ev  <= ev_pend;
                    idx          <= 4'd0;
                    chk          <= 8'h00;
                    frame_buf[0] <= HEADER;
                    if (ev_pend) begin
                        frame_buf[1] <= 8'h02;
                        frame_buf[2] <= 8'h01;
                        frame_buf[3] <= ev_code;
                        for (int i = 4; i < 9; i++) frame_buf[i] <= 8'h00;
                    end else begin
                        frame_buf[1] <= 8'h01;
                        frame_buf[2] <= 8'h06;
                        frame_buf[3] <= speed;
                        frame_buf[4] <= heartRate;
                        frame_buf[5] <= {6'b0, resolvedAngle[9:8]};
                        frame_buf[6] <= resolvedAngle[7:0];
                        frame_buf[7] <= {4'b0, adcData[11:8]};
                        frame_buf[8] <= adcData[7:0];
                    end
                end
                S_SEND: begin
                    tx_hold <= cur_byte;
                    if (idx != 4'd0 && !is_last) chk <= chk ^ cur_byte;
                end
                S_WAIT: begin
                    if (!is_transmitting) begin
                        if (is_last) begin
                            if (!frame_is_ev) frame_count <= frame_count + 8'd1;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_telemetry_tx_scheduler.sv
// Directed bench for telemetry_tx_scheduler with a simple UART occupancy model
// and a byte scoreboard.
module tb_telemetry_tx_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  speed = 8'h00;
    logic [7:0]  heart_rate = 8'h00;
    logic [9:0]  angle = 10'h000;
    logic [11:0] adc = 12'h000;
    logic        event_req = 1'b0;
    logic [7:0]  event_code = 8'h00;
    logic        is_transmitting;
    logic        transmit;
    logic [7:0]  tx_byte;
    logic        busy;
    logic [7:0]  frame_count;
    logic        overrun;
    logic        event_drop;
    logic [2:0]  state_dbg;

    int n_tests = 0;
    int n_fail  = 0;
    int uart_len = 20;
    int uart_cnt = 0;
    logic prev_tx = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    telemetry_tx_scheduler #(.PERIOD_CYCLES(100), .HEADER(8'hA5)) dut (
        .c50M(clk), .reset(reset), .speed(speed), .heartRate(heart_rate),
        .resolvedAngle(angle), .adcData(adc), .event_req(event_req),
        .event_code(event_code), .is_transmitting(is_transmitting),
        .transmit(transmit), .tx_byte(tx_byte), .busy(busy),
        .frame_count(frame_count), .overrun(overrun), .event_drop(event_drop),
        .state_dbg(state_dbg)
    );

    assign is_transmitting = (uart_cnt != 0);

    // UART model: a byte keeps the line busy for uart_len cycles after its request.
    always @(negedge clk) begin
        if (transmit) begin
            n_tests++;
            assert (is_transmitting === 1'b0) else begin
                n_fail++;
                $error("FAIL issue_while_busy obs=%0b exp=0", is_transmitting);
            end
            n_tests++;
            assert (prev_tx === 1'b0) else begin
                n_fail++;
                $error("FAIL back_to_back_transmit obs=%0b exp=0", prev_tx);
            end
            got_q.push_back(tx_byte);
            uart_cnt = uart_len;
        end else if (uart_cnt > 0) begin
            uart_cnt--;
        end
        prev_tx = transmit;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        event_req = 1'b0;
        repeat (2) @(negedge clk);
        got_q.delete();
        exp_q.delete();
        reset = 1'b0;
    endtask

    task automatic push_tel();
        exp_q.push_back(8'hA5); exp_q.push_back(8'h01); exp_q.push_back(8'h06);
        exp_q.push_back(8'h20); exp_q.push_back(8'h50); exp_q.push_back(8'h01);
        exp_q.push_back(8'h55); exp_q.push_back(8'h0A); exp_q.push_back(8'hBC);
        exp_q.push_back(8'h95);
    endtask

    task automatic push_ev(input logic [7:0] code, input logic [7:0] chk);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h02); exp_q.push_back(8'h01);
        exp_q.push_back(code);  exp_q.push_back(chk);
    endtask

    task automatic wait_frames(input int n, input int limit, input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (got_q.size() >= n && busy === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        check({tag, "_done"}, done, 1);
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_transmit"}, transmit, 0);
        check({tag, "_tx_byte"}, tx_byte, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_count"}, frame_count, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_event_drop"}, event_drop, 0);
    endtask

    initial begin
        int  seen;
        logic bad;

        // Reset state
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        check("reset_state", state_dbg, 0);
        speed = 8'h20; heart_rate = 8'h50; angle = 10'h155; adc = 12'hABC;

        // 1: first telemetry frame, 20 cycles per byte
        do_reset();
        uart_len = 20;
        push_tel();
        wait_frames(10, 1000, "t1");
        check_frame("t1");
        check("t1_frame_count", frame_count, 1);

        // 2: event frame from idle
        do_reset();
        event_req = 1'b1; event_code = 8'h42;
        @(negedge clk);
        event_req = 1'b0;
        push_ev(8'h42, 8'h41);
        wait_frames(5, 1000, "t2");
        check_frame("t2");
        check("t2_frame_count", frame_count, 0);

        // 3: event_req coincident with the first tick; fast UART
        do_reset();
        uart_len = 2;
        repeat (99) @(negedge clk);
        event_req = 1'b1; event_code = 8'h5A;
        @(negedge clk);
        event_req = 1'b0;
        check("t3_lat_n_transmit", transmit, 0);
        check("t3_lat_n_busy", busy, 0);
        @(negedge clk);
        check("t3_lat_n1_transmit", transmit, 0);
        check("t3_lat_n1_busy", busy, 1);
        @(negedge clk);
        check("t3_lat_n2_transmit", transmit, 1);
        check("t3_lat_n2_byte", tx_byte, 8'hA5);
        push_ev(8'h5A, 8'h59);
        push_tel();
        wait_frames(15, 500, "t3");
        check_frame("t3");
        check("t3_frame_count", frame_count, 1);
        check("t3_overrun", overrun, 0);
        check("t3_event_drop", event_drop, 0);

        // 4: slow UART, ticks pile up, inputs change mid-frame
        do_reset();
        uart_len = 200;
        repeat (110) @(negedge clk);
        speed = 8'hFF; heart_rate = 8'hEE; angle = 10'h3FF; adc = 12'h123;
        repeat (40) @(negedge clk);
        check("t4_overrun_early", overrun, 0);
        repeat (200) @(negedge clk);
        check("t4_overrun_late", overrun, 1);
        push_tel();
        wait_frames(10, 5000, "t4");
        check_frame("t4");
        check("t4_frame_count", frame_count, 1);
        speed = 8'h20; heart_rate = 8'h50; angle = 10'h155; adc = 12'hABC;

        // 5: two events 3 cycles apart during a telemetry frame
        do_reset();
        uart_len = 20;
        repeat (120) @(negedge clk);
        event_req = 1'b1; event_code = 8'h33;
        @(negedge clk);
        event_req = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_drop_before", event_drop, 0);
        event_req = 1'b1; event_code = 8'h44;
        @(negedge clk);
        event_req = 1'b0;
        check("t5_drop_after", event_drop, 1);
        push_tel();
        push_ev(8'h33, 8'h30);
        wait_frames(15, 2000, "t5");
        check_frame("t5");
        check("t5_frame_count", frame_count, 1);

        // 6: reset at the 4th byte of a telemetry frame
        do_reset();
        uart_len = 20;
        seen = 0;
        for (int i = 0; i < 1000 && seen < 4; i++) begin
            @(negedge clk);
            if (transmit === 1'b1) seen++;
        end
        check("t6_reached_byte4", seen, 4);
        reset = 1'b1;
        @(negedge clk);
        check_zero_outputs("t6_reset");
        got_q.delete();
        exp_q.delete();
        reset = 1'b0;
        event_req = 1'b1; event_code = 8'h77;
        @(negedge clk);
        event_req = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 100 && is_transmitting; i++) begin
            if (transmit !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        check("t6_quiet_while_uart_busy", bad, 0);
        check("t6_uart_drained", is_transmitting, 0);
        push_ev(8'h77, 8'h74);
        wait_frames(5, 1000, "t6");
        check_frame("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
